audio_in_fifo_ci: RTL

AUDIO_IN_FIFO_CI -- requirements
Module: audio_in_fifo_ci

---
 rtl/audio_in_fifo_ci.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_in_fifo_ci.sv
// audio_in_fifo_ci: I2S left-channel capture into a sample FIFO, read
// through a custom-instruction port (POP / STATUS / FLUSH / NOP).
// Ports: clk, reset (async, high); clk_en, start, dataa[1:0] = command,
//   datab unused; result (registered), done (1-cycle pulse);
//   i2s_bclk, i2s_lrclk, i2s_adcdat (async codec inputs); overflow (sticky).
module audio_in_fifo_ci #(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  input  logic        i2s_bclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_adcdat,
  output logic        overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(SAMPLE_W + 1);

  localparam logic [1:0] CMD_POP    = 2'd0;
  localparam logic [1:0] CMD_STATUS = 2'd1;
  localparam logic [1:0] CMD_FLUSH  = 2'd2;
  localparam logic [1:0] CMD_NOP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  // synchronizers and bclk edge detect
  logic [1:0] bclk_sync_q;
  logic [1:0] lr_sync_q;
  logic [1:0] dat_sync_q;
  logic       bclk_prev_q;
  logic       bclk_rise_w;
  logic       lr_s_w;
  logic       dat_s_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[0], i2s_lrclk};
      dat_sync_q  <= {dat_sync_q[0], i2s_adcdat};
      bclk_prev_q <= bclk_sync_q[1];
    end
  end

  assign bclk_rise_w = bclk_sync_q[1] & ~bclk_prev_q;
  assign lr_s_w      = lr_sync_q[1];
  assign dat_s_w     = dat_sync_q[1];

  // deserializer
  logic                lr_prev_q, lr_prev_d;
  logic                active_q, active_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                push_q, push_d;

  always_comb begin
    lr_prev_d = lr_prev_q;
    active_d  = active_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    if (bclk_rise_w) begin
      if (lr_s_w != lr_prev_q) begin
        // word boundary: MSB arrives on the next edge;
        // any partial word is dropped here
        lr_prev_d = lr_s_w;
        active_d  = ~lr_s_w;
        bcnt_d    = '0;
      end else if (active_q) begin
        shift_d = {shift_q[SAMPLE_W-2:0], dat_s_w};
        bcnt_d  = bcnt_q + BCW'(1);
        if (bcnt_q == BCW'(SAMPLE_W - 1)) begin
          active_d = 1'b0;
          push_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lr_prev_q <= 1'b0;
      active_q  <= 1'b0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      lr_prev_q <= lr_prev_d;
      active_q  <= active_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
    end
  end

  // 16-bit view of the sample as stored in the FIFO
  logic [15:0] samp16_w;

  if (SAMPLE_W >= 16) begin : g_trunc
    assign samp16_w = shift_q[SAMPLE_W-1 -: 16];
  end else begin : g_ext
    assign samp16_w = {{(16 - SAMPLE_W){1'b0}}, shift_q};
  end

  // FIFO
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full_w;
  logic          empty_w;
  logic          wr_en_w;
  logic          pop_w;
  logic          flush_w;

  assign full_w  = (cnt_q == CW'(DEPTH));
  assign empty_w = (cnt_q == '0);
  assign wr_en_w = push_q & ~flush_w & (~full_w | pop_w);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (flush_w) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (wr_en_w) wr_d = wr_q + AW'(1);
      if (pop_w)   rd_d = rd_q + AW'(1);
      if (push_q && full_w && !pop_w) ovf_d = 1'b1;
      if (wr_en_w && !pop_w) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!wr_en_w && pop_w) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_w) mem_q[wr_q] <= samp16_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // custom-instruction FSM
  state_t      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    done_d   = 1'b0;
    pop_w    = 1'b0;
    flush_w  = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cmd_d   = dataa[1:0];
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          done_d  = 1'b1;
          state_d = S_DONE;
          case (cmd_q)
            CMD_POP: begin
              if (empty_w) begin
                result_d = 32'h0001_0000;
              end else begin
                result_d = {16'h0, mem_q[rd_q]};
                pop_w    = 1'b1;
              end
            end
            CMD_STATUS: begin
              result_d = {ovf_q, 23'h0, 8'(cnt_q)};
            end
            CMD_FLUSH: begin
              result_d = '0;
              flush_w  = 1'b1;
            end
            CMD_NOP: begin
              result_d = '0;
            end
          endcase
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_NOP;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign overflow = ovf_q;

  logic unused_w;
  assign unused_w = ^{datab, dataa[31:2], shift_q};

endmodule
